// File: rtl/bcd_time_counter.sv
// 24-hour BCD time-of-day counter with 1 Hz prescaler and range-checked load.
// All outputs are registered; digits are always legal BCD within their field.
module bcd_time_counter #(
  parameter int unsigned TICK_DIV = 50000000,
  parameter int unsigned CNT_W    = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       load,
  input  logic [7:0] load_hh,
  input  logic [7:0] load_mm,
  input  logic [7:0] load_ss,
  output logic [3:0] sec_ones,
  output logic [3:0] sec_tens,
  output logic [3:0] min_ones,
  output logic [3:0] min_tens,
  output logic [3:0] hr_ones,
  output logic [3:0] hr_tens,
  output logic       sec_tick,
  output logic       day_wrap,
  output logic       load_err
);

  localparam logic [CNT_W-1:0] LP_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_presc;
  logic [3:0]       r_s1, r_s10, r_m1, r_m10, r_h1, r_h10;
  logic             r_tick, r_wrap, r_err;

  logic             w_tick;
  logic             w_load_ok;
  logic             w_c_s1, w_c_s10, w_c_m1, w_c_m10, w_h23;
  logic [3:0]       w_s1, w_s10, w_m1, w_m10, w_h1, w_h10;

  assign w_tick = en && (r_presc == LP_LAST);

  assign w_load_ok = (load_ss[3:0] <= 4'd9) && (load_ss[7:4] <= 4'd5)
                  && (load_mm[3:0] <= 4'd9) && (load_mm[7:4] <= 4'd5)
                  && (load_hh[3:0] <= 4'd9) && (load_hh <= 8'h23);

  // Ripple carries resolve in one edge, so 23:59:59 -> 00:00:00 is atomic
  assign w_c_s1  = (r_s1 == 4'd9);
  assign w_c_s10 = w_c_s1 && (r_s10 == 4'd5);
  assign w_c_m1  = w_c_s10 && (r_m1 == 4'd9);
  assign w_c_m10 = w_c_m1 && (r_m10 == 4'd5);
  assign w_h23   = (r_h10 == 4'd2) && (r_h1 == 4'd3);

  always_comb begin
    w_s1  = w_c_s1 ? 4'd0 : r_s1 + 4'd1;
    w_s10 = r_s10;
    w_m1  = r_m1;
    w_m10 = r_m10;
    w_h1  = r_h1;
    w_h10 = r_h10;
    if (w_c_s1)
      w_s10 = w_c_s10 ? 4'd0 : r_s10 + 4'd1;
    if (w_c_s10)
      w_m1 = w_c_m1 ? 4'd0 : r_m1 + 4'd1;
    if (w_c_m1)
      w_m10 = w_c_m10 ? 4'd0 : r_m10 + 4'd1;
    if (w_c_m10) begin
      if (w_h23) begin
        w_h1  = 4'd0;
        w_h10 = 4'd0;
      end else if (r_h1 == 4'd9) begin
        w_h1  = 4'd0;
        w_h10 = r_h10 + 4'd1;
      end else begin
        w_h1 = r_h1 + 4'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc <= '0;
      r_s1    <= '0;
      r_s10   <= '0;
      r_m1    <= '0;
      r_m10   <= '0;
      r_h1    <= '0;
      r_h10   <= '0;
      r_tick  <= 1'b0;
      r_wrap  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_tick <= 1'b0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
      if (load && w_load_ok) begin
        r_presc <= '0;
        r_s1    <= load_ss[3:0];
        r_s10   <= load_ss[7:4];
        r_m1    <= load_mm[3:0];
        r_m10   <= load_mm[7:4];
        r_h1    <= load_hh[3:0];
        r_h10   <= load_hh[7:4];
      end else begin
        r_err <= load;
        if (w_tick) begin
          r_presc <= '0;
          r_s1    <= w_s1;
          r_s10   <= w_s10;
          r_m1    <= w_m1;
          r_m10   <= w_m10;
          r_h1    <= w_h1;
          r_h10   <= w_h10;
          r_tick  <= 1'b1;
          r_wrap  <= w_c_m10 && w_h23;
        end else if (en) begin
          r_presc <= r_presc + 1'b1;
        end
      end
    end
  end

  assign sec_ones = r_s1;
  assign sec_tens = r_s10;
  assign min_ones = r_m1;
  assign min_tens = r_m10;
  assign hr_ones  = r_h1;
  assign hr_tens  = r_h10;
  assign sec_tick = r_tick;
  assign day_wrap = r_wrap;
  assign load_err = r_err;

endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: directed plan plus random traffic,
// checked against a seconds-of-day arithmetic model.
module tb_bcd_time_counter;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst, en, load;
  logic [7:0] load_hh, load_mm, load_ss;
  logic [3:0] sec_ones, sec_tens, min_ones, min_tens, hr_ones, hr_tens;
  logic       sec_tick, day_wrap, load_err;

  int checks = 0;
  int errors = 0;

  int m_sec, m_presc;
  bit m_tick, m_wrap, m_err;

  bcd_time_counter #(.TICK_DIV(TD), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .load(load),
    .load_hh(load_hh), .load_mm(load_mm), .load_ss(load_ss),
    .sec_ones(sec_ones), .sec_tens(sec_tens),
    .min_ones(min_ones), .min_tens(min_tens),
    .hr_ones(hr_ones), .hr_tens(hr_tens),
    .sec_tick(sec_tick), .day_wrap(day_wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int bcd_val(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic bit ok_load(input logic [7:0] hh, mm, ss);
    int h, mi, s;
    if (hh[3:0] > 9 || mm[3:0] > 9 || ss[3:0] > 9) return 0;
    if (hh[7:4] > 9 || mm[7:4] > 9 || ss[7:4] > 9) return 0;
    h = bcd_val(hh); mi = bcd_val(mm); s = bcd_val(ss);
    return (h < 24) && (mi < 60) && (s < 60);
  endfunction

  function automatic logic [23:0] exp_time(input int t);
    int h, mi, s;
    h = t / 3600; mi = (t / 60) % 60; s = t % 60;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10),
            4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic cyc(input string tag, input bit r, e, l,
                     input logic [7:0] hh, mm, ss);
    rst = r; en = e; load = l;
    load_hh = hh; load_mm = mm; load_ss = ss;
    @(posedge clk);
    m_tick = 0; m_wrap = 0; m_err = 0;
    if (r) begin
      m_sec = 0; m_presc = 0;
    end else if (l && ok_load(hh, mm, ss)) begin
      m_sec = bcd_val(hh) * 3600 + bcd_val(mm) * 60 + bcd_val(ss);
      m_presc = 0;
    end else begin
      m_err = l;
      if (e) begin
        if (m_presc == TD - 1) begin
          m_presc = 0;
          m_sec = (m_sec + 1) % 86400;
          m_tick = 1;
          m_wrap = (m_sec == 0);
        end else begin
          m_presc++;
        end
      end
    end
    #1;
    chk({tag, ".time"},
        {hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones},
        exp_time(m_sec));
    chk({tag, ".tick"}, sec_tick, m_tick);
    chk({tag, ".wrap"}, day_wrap, m_wrap);
    chk({tag, ".err"}, load_err, m_err);
  endtask

  task automatic run(input string tag, input int n, input bit e);
    for (int i = 0; i < n; i++) cyc(tag, 0, e, 0, 8'h00, 8'h00, 8'h00);
  endtask

  initial begin
    logic [7:0] rh, rm, rs;
    m_sec = 0; m_presc = 0;
    rst = 1; en = 0; load = 0;
    load_hh = 0; load_mm = 0; load_ss = 0;

    cyc("reset", 1, 0, 0, 8'h00, 8'h00, 8'h00);
    cyc("reset", 1, 1, 1, 8'h12, 8'h34, 8'h56);

    run("count12", 12, 1);
    chk("count12.sec_ones", sec_ones, 3);

    cyc("ld_000059", 0, 1, 1, 8'h00, 8'h00, 8'h59);
    run("carry", 4, 1);
    chk("carry.min_ones", min_ones, 1);
    run("carry", 12, 1);

    cyc("ld_235959", 0, 1, 1, 8'h23, 8'h59, 8'h59);
    run("daywrap", 4, 1);
    chk("daywrap.pulse", {sec_tick, day_wrap}, 2'b11);
    run("daywrap", 4, 1);

    cyc("ld_095959", 0, 1, 1, 8'h09, 8'h59, 8'h59);
    run("to10", 4, 1);
    chk("to10.hr", {hr_tens, hr_ones}, 8'h10);
    cyc("ld_195959", 0, 1, 1, 8'h19, 8'h59, 8'h59);
    run("to20", 4, 1);
    chk("to20.hr", {hr_tens, hr_ones}, 8'h20);

    cyc("bad_24", 0, 1, 1, 8'h24, 8'h00, 8'h00);
    run("bad", 2, 1);
    cyc("bad_m60", 0, 1, 1, 8'h12, 8'h60, 8'h00);
    run("bad", 1, 1);
    cyc("bad_1A", 0, 1, 1, 8'h1A, 8'h00, 8'h00);
    run("bad", 3, 1);

    cyc("ld_pre", 0, 1, 1, 8'h11, 8'h22, 8'h33);
    run("ld_pre", 3, 1);
    cyc("ld_on_tick", 0, 1, 1, 8'h05, 8'h06, 8'h07);
    chk("ld_on_tick.tick", sec_tick, 0);
    run("after_ld", 4, 1);
    chk("after_ld.tick", sec_tick, 1);

    run("pre_freeze", 2, 1);
    run("freeze", 10, 0);
    run("resume", 6, 1);

    cyc("rst_pre", 0, 1, 1, 8'h08, 8'h08, 8'h08);
    run("rst_pre", 3, 1);
    cyc("rst_all", 1, 1, 1, 8'h15, 8'h15, 8'h15);
    chk("rst_all.pulses", {sec_tick, day_wrap, load_err}, 3'b000);

    for (int i = 0; i < 600; i++) begin
      rh = 8'($urandom_range(0, 8'h2F));
      rm = 8'($urandom_range(0, 8'h6B));
      rs = 8'($urandom_range(0, 8'h6B));
      if ($urandom_range(0, 3) == 0) rm = 8'h59;
      if ($urandom_range(0, 3) == 0) rs = 8'h59;
      cyc("rand", $urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
          $urandom_range(0, 14) == 0, rh, rm, rs);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
